// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory behind a valid/ready request
// channel and a valid/ready response channel. Each accepted request waits
// LATENCY cycles before its response is presented. Stores commit on the edge
// that enters the response state. Loads are returned sign- or zero-extended
// according to the RISC-V funct3 code.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle
//   req_write         1 = store, 0 = load
//   req_addr          byte address (word index = addr[31:2])
//   req_wdata         right-aligned store data
//   req_size          funct3: lb/lh/lw/lbu/lhu, sb/sh/sw
//   resp_valid/ready  response handshake
//   resp_rdata        formatted load data (0 for stores and errors)
//   resp_err          misaligned, out-of-range or illegal-size request

module data_mem_responder_lane (
  input  logic       be,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = be ? new_b : old_b;
endmodule

module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int NUM_LANES = 4;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t  req_in, req_q, cur;
  resp_t resp_q, resp_d;
  logic [DEPTH_WORDS-1:0][31:0] mem;

  logic accept, enter_resp;

  assign req_in     = '{write: req_write, addr: req_addr, wdata: req_wdata, size: req_size};
  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

  // Next state / counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the request executes on its own accept edge, so the
  // live inputs are used instead of the (not yet loaded) capture register.
  assign cur = (state_q == IDLE) ? req_in : req_q;

  logic [1:0]    bo;
  logic          in_range, bad_size, err, we;
  logic [AW-1:0] widx;
  logic [31:0]   rword, wlane, wword, ld;
  logic [15:0]   shifted;
  logic [NUM_LANES-1:0] be;

  assign bo       = cur.addr[1:0];
  assign in_range = cur.addr[31:2] < 30'(DEPTH_WORDS);
  assign widx     = cur.addr[AW+1:2];
  assign rword    = in_range ? mem[widx] : 32'd0;
  assign shifted  = 16'(rword >> {bo, 3'b000});

  always_comb begin
    case (cur.size)
      3'b000:  bad_size = 1'b0;
      3'b001:  bad_size = bo[0];
      3'b010:  bad_size = |bo;
      3'b100:  bad_size = cur.write;
      3'b101:  bad_size = cur.write | bo[0];
      default: bad_size = 1'b1;
    endcase
  end

  assign err = bad_size | ~in_range;
  assign we  = enter_resp & cur.write & ~err;

  always_comb begin
    case (cur.size)
      3'b000:  ld = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld = {24'd0, shifted[7:0]};
      3'b001:  ld = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld = {16'd0, shifted[15:0]};
      3'b010:  ld = rword;
      default: ld = 32'd0;
    endcase
  end

  assign resp_d.rdata = (err | cur.write) ? 32'd0 : ld;
  assign resp_d.err   = err;

  // Store data replicated across lanes; byte enables pick the target lanes.
  always_comb begin
    case (cur.size[1:0])
      2'b00: begin
        be    = 4'b0001 << bo;
        wlane = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << bo;
        wlane = {2{cur.wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = cur.wdata;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_mem_responder_lane u_lane (
      .be    (be[i]),
      .old_b (rword[8*i +: 8]),
      .new_b (wlane[8*i +: 8]),
      .out_b (wword[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      resp_q  <= '0;
      mem     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= req_in;
      if (enter_resp) begin
        resp_q <= resp_d;
        if (we) mem[widx] <= wword;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: idle-ready, accept, garbage on inputs afterwards,
  // response 3 cycles after accept (LATENCY=2), consume, data held in idle.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] sz,
                      input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = sz;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_size = 3'b010;
    chk({tag, " req_ready wait"}, 32'(req_ready), 32'd0);
    chk({tag, " resp_valid c1"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, " resp_valid c2"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, " resp_valid c3"}, 32'(resp_valid), 32'd1);
    chk({tag, " rdata"}, resp_rdata, exp_d);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_e));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " resp_valid done"}, 32'(resp_valid), 32'd0);
    chk({tag, " rdata held"}, resp_rdata, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    #12;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Word store / load, then sub-word loads
    xact("sw 10",  1'b1, 32'h10, 32'h8000_00F1, 3'b010, 32'h0, 1'b0);
    xact("lw 10",  1'b0, 32'h10, 32'h0,         3'b010, 32'h8000_00F1, 1'b0);
    xact("lb 10",  1'b0, 32'h10, 32'h0,         3'b000, 32'hFFFF_FFF1, 1'b0);
    xact("lbu 13", 1'b0, 32'h13, 32'h0,         3'b100, 32'h0000_0080, 1'b0);
    xact("lh 12",  1'b0, 32'h12, 32'h0,         3'b001, 32'hFFFF_8000, 1'b0);
    xact("lhu 10", 1'b0, 32'h10, 32'h0,         3'b101, 32'h0000_00F1, 1'b0);

    // Partial stores only touch their lanes
    xact("sh 12",  1'b1, 32'h12, 32'h1234_ABCD, 3'b001, 32'h0, 1'b0);
    xact("lw 10b", 1'b0, 32'h10, 32'h0,         3'b010, 32'hABCD_00F1, 1'b0);
    xact("sb 11",  1'b1, 32'h11, 32'hFFFF_FF55, 3'b000, 32'h0, 1'b0);
    xact("lw 10c", 1'b0, 32'h10, 32'h0,         3'b010, 32'hABCD_55F1, 1'b0);

    // Rejected requests
    xact("lw 12 mis",   1'b0, 32'h12,  32'h0,  3'b010, 32'h0, 1'b1);
    xact("sh 13 mis",   1'b1, 32'h13,  32'hFFFF, 3'b001, 32'h0, 1'b1);
    xact("lw oor",      1'b0, 32'h400, 32'h0,  3'b010, 32'h0, 1'b1);
    xact("size 011",    1'b0, 32'h10,  32'h0,  3'b011, 32'h0, 1'b1);
    xact("store sz100", 1'b1, 32'h10,  32'h77, 3'b100, 32'h0, 1'b1);
    xact("sw 11 mis",   1'b1, 32'h11,  32'h0,  3'b010, 32'h0, 1'b1);
    xact("lw 10 intact",1'b0, 32'h10,  32'h0,  3'b010, 32'hABCD_55F1, 1'b0);

    // Backpressure: response held for 5 cycles, req_valid kept high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("stall first valid", 32'(resp_valid), 32'd1);
    held = resp_rdata;
    chk("stall rdata", held, 32'hABCD_55F1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall valid %0d", i), 32'(resp_valid), 32'd1);
      chk($sformatf("stall rdata %0d", i), resp_rdata, held);
      chk($sformatf("stall req_ready %0d", i), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bubble req_ready", 32'(req_ready), 32'd1);
    chk("bubble resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("reaccept req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("reaccept valid c2", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("reaccept valid c3", 32'(resp_valid), 32'd1);
    chk("reaccept rdata", resp_rdata, 32'hABCD_55F1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during WAIT of a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_size = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre-rst rdata", resp_rdata, 32'hABCD_55F1);
    rst = 1'b0;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    // Request already pending when reset lifts is taken on the first edge
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_size = 3'b010;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post-rst accept", 32'(req_ready), 32'd0);
    chk("post-rst valid c1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("post-rst valid c2", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("post-rst valid c3", 32'(resp_valid), 32'd1);
    chk("post-rst lw 20", resp_rdata, 32'd0);
    chk("post-rst err", 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no stray valid %0d", i), 32'(resp_valid), 32'd0);
    end
    xact("lw 10 cleared", 1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
